// File: rtl/sd_card_cmd_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_pkg : shared types and constants for the SD CMD line endpoints     |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
package sd_pkg;

  localparam int          SD_FRAME_BITS = 48;
  localparam int          SD_CRC_BITS   = 7;
  localparam logic [6:0]  SD_CRC7_POLY  = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RECV = 3'd1,
    ST_EVAL = 3'd2,
    ST_GAP  = 3'd3,
    ST_SEND = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sd_card_cmd_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_card_cmd_responder_if : CMD line and card-logic handshake bundle   |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
interface sd_card_cmd_responder_if;

  logic        cmd_pin_in;
  logic        cmd_pin_out;
  logic        cmd_pin_oe;
  logic        cmd_valid;
  logic        cmd_error;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic [31:0] rsp_status;
  logic        rsp_none;
  logic        busy;

  // master: host line plus card logic; slave: the responder itself
  modport master (
    output cmd_pin_in, rsp_status, rsp_none,
    input  cmd_pin_out, cmd_pin_oe, cmd_valid, cmd_error,
           cmd_index, cmd_argument, busy
  );

  modport slave (
    input  cmd_pin_in, rsp_status, rsp_none,
    output cmd_pin_out, cmd_pin_oe, cmd_valid, cmd_error,
           cmd_index, cmd_argument, busy
  );

endinterface
`default_nettype wire

// File: rtl/sd_card_cmd_responder_crc7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_crc7 : serial CRC7 (x^7+x^3+1), init 0, clear has priority         |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
module sd_crc7
  import sd_pkg::*;
(
  input  wire logic                   clock,
  input  wire logic                   reset,
  input  wire logic                   clear,
  input  wire logic                   enable,
  input  wire logic                   bit_in,
  output logic [SD_CRC_BITS-1:0]      crc
);

  logic [SD_CRC_BITS-1:0] r_crc;
  logic                   w_fb;

  assign w_fb = bit_in ^ r_crc[SD_CRC_BITS-1];
  assign crc  = r_crc;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_crc <= '0;
    end else if (enable) begin
      r_crc <= {r_crc[SD_CRC_BITS-2:0], 1'b0} ^ (w_fb ? SD_CRC7_POLY : 7'h00);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_card_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_card_cmd_responder : card-side CMD frame receiver and R1-style     |
// | short-response transmitter with programmable NCR gap                  |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
module sd_card_cmd_responder
  import sd_pkg::*;
#(
  parameter int NCR = 2
)(
  input  wire logic                 clock,
  input  wire logic                 reset,
  sd_card_cmd_responder_if.slave    bus
);

  localparam logic [5:0] c_GAP_LOAD = 6'(NCR - 1);

  if (NCR < 2 || NCR > 64) begin : g_ncr_range
    $error("NCR must be in 2..64");
  end

  state_t        r_state, w_next;
  logic [47:0]   r_shift;
  logic [39:0]   r_tx;
  logic [5:0]    r_bit_cnt;
  logic [5:0]    r_gap_cnt;
  logic [5:0]    r_index;
  logic [31:0]   r_arg;
  logic [6:0]    w_crc;
  logic          w_frame_ok;
  logic          w_crc_clear, w_crc_en, w_crc_bit;
  logic          w_valid, w_error, w_oe, w_out;

  sd_crc7 u_crc7 (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_crc_clear),
    .enable (w_crc_en),
    .bit_in (w_crc_bit),
    .crc    (w_crc)
  );

  assign w_frame_ok = (r_shift[47] == 1'b0) && r_shift[46] && r_shift[0] &&
                      (r_shift[7:1] == w_crc);

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_valid     = 1'b0;
    w_error     = 1'b0;
    w_oe        = 1'b0;
    w_out       = 1'b1;
    w_crc_clear = 1'b0;
    w_crc_en    = 1'b0;
    w_crc_bit   = bus.cmd_pin_in;
    case (r_state)
      ST_IDLE: begin
        if (!bus.cmd_pin_in) begin
          w_next      = ST_RECV;
          w_crc_clear = 1'b1;
        end
      end
      ST_RECV: begin
        // bit counter equals the index of the bit being sampled
        w_crc_en = (r_bit_cnt >= 6'd8);
        if (r_bit_cnt == 6'd0) w_next = ST_EVAL;
      end
      ST_EVAL: begin
        if (w_frame_ok) begin
          w_valid = 1'b1;
          w_next  = bus.rsp_none ? ST_IDLE : ST_GAP;
        end else begin
          w_error = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == 6'd0) begin
          w_next      = ST_SEND;
          w_crc_clear = 1'b1;
        end
      end
      ST_SEND: begin
        w_oe      = 1'b1;
        w_crc_bit = r_tx[39];
        if (r_bit_cnt >= 6'd8) begin
          w_out    = r_tx[39];
          w_crc_en = 1'b1;
        end else if (r_bit_cnt == 6'd0) begin
          w_out  = 1'b1;
          w_next = ST_IDLE;
        end else begin
          w_out = w_crc[r_bit_cnt[2:0] - 3'd1];
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift   <= '0;
      r_tx      <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_index   <= '0;
      r_arg     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.cmd_pin_in) begin
            r_shift   <= '0;
            r_bit_cnt <= 6'd46;
          end
        end
        ST_RECV: begin
          r_shift   <= {r_shift[46:0], bus.cmd_pin_in};
          r_bit_cnt <= r_bit_cnt - 6'd1;
        end
        ST_EVAL: begin
          if (w_frame_ok) begin
            r_index   <= r_shift[45:40];
            r_arg     <= r_shift[39:8];
            r_tx      <= {2'b00, r_shift[45:40], bus.rsp_status};
            r_gap_cnt <= c_GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 6'd0) r_bit_cnt <= 6'd47;
          else                   r_gap_cnt <= r_gap_cnt - 6'd1;
        end
        ST_SEND: begin
          r_tx      <= {r_tx[38:0], 1'b0};
          r_bit_cnt <= r_bit_cnt - 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_pin_out  = w_out;
  assign bus.cmd_pin_oe   = w_oe;
  assign bus.cmd_valid    = w_valid;
  assign bus.cmd_error    = w_error;
  assign bus.cmd_index    = r_index;
  assign bus.cmd_argument = r_arg;
  assign bus.busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sd_card_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sd_card_cmd_responder : scoreboard bench for the card CMD endpoint |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
module tb_sd_card_cmd_responder;

  localparam int c_NCR = 2;

  typedef struct {
    bit          good;
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          rsp;
    logic [47:0] rsp_bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic [5:0]  exp_idx = '0;
  logic [31:0] exp_arg = '0;

  sd_card_cmd_responder_if bus ();

  sd_card_cmd_responder #(.NCR(c_NCR)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Drives one frame (optionally aborted by reset during the response) and
  // checks decode, held fields and the serialised response.
  task automatic run_frame(input logic [47:0] frame, input logic [31:0] status,
                           input bit none, input bit toggle, input int abort_bit);
    exp_t        e;
    logic [47:0] got;
    int          first_t;
    int          oe_cnt;
    e.good = (frame[47] == 1'b0) && frame[46] && frame[0] &&
             (crc7(frame[47:8]) == frame[7:1]);
    if (e.good) begin
      exp_idx = frame[45:40];
      exp_arg = frame[39:8];
    end
    e.idx      = exp_idx;
    e.arg      = exp_arg;
    e.rsp      = e.good && !none;
    e.rsp_bits = {2'b00, frame[45:40], status,
                  crc7({2'b00, frame[45:40], status}), 1'b1};
    sb.push_back(e);
    bus.rsp_status = status;
    bus.rsp_none   = none;
    for (int i = 47; i >= 0; i--) begin
      bus.cmd_pin_in = frame[i];
      @(posedge clk); #1;
    end
    bus.cmd_pin_in = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (bus.cmd_valid !== e.good) begin
      fails++;
      $display("FAIL cmd_valid@S+48 frame=%h got=%b exp=%b", frame, bus.cmd_valid, e.good);
    end
    tests++;
    if (bus.cmd_error !== !e.good) begin
      fails++;
      $display("FAIL cmd_error@S+48 frame=%h got=%b exp=%b", frame, bus.cmd_error, !e.good);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.cmd_index !== e.idx) begin
      fails++;
      $display("FAIL cmd_index frame=%h got=%0d exp=%0d", frame, bus.cmd_index, e.idx);
    end
    tests++;
    if (bus.cmd_argument !== e.arg) begin
      fails++;
      $display("FAIL cmd_argument frame=%h got=%h exp=%h", frame, bus.cmd_argument, e.arg);
    end
    if (!e.rsp) begin
      tests++;
      if (bus.cmd_pin_oe !== 1'b0 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL no_response_idle frame=%h oe=%b busy=%b exp oe=0 busy=0",
                 frame, bus.cmd_pin_oe, bus.busy);
      end
      return;
    end
    got     = '0;
    first_t = -1;
    oe_cnt  = 0;
    for (int t = 49; t <= 100 + c_NCR; t++) begin
      if (abort_bit >= 0 && t == 49 + c_NCR + abort_bit) begin
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.cmd_pin_oe !== 1'b0 || bus.cmd_pin_out !== 1'b1 || bus.busy !== 1'b0) begin
          fails++;
          $display("FAIL reset_mid_send oe=%b out=%b busy=%b exp oe=0 out=1 busy=0",
                   bus.cmd_pin_oe, bus.cmd_pin_out, bus.busy);
        end
        rst     = 1'b0;
        exp_idx = '0;
        exp_arg = '0;
        return;
      end
      if (bus.cmd_pin_oe === 1'b1) begin
        if (first_t < 0) first_t = t;
        oe_cnt++;
      end
      if (t >= 49 + c_NCR && t <= 96 + c_NCR) got[96 + c_NCR - t] = bus.cmd_pin_out;
      if (toggle && t >= 49 + c_NCR && t <= 96 + c_NCR) bus.cmd_pin_in = 1'(t % 2);
      else                                             bus.cmd_pin_in = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (first_t != 49 + c_NCR) begin
      fails++;
      $display("FAIL rsp_start frame=%h got=S+%0d exp=S+%0d", frame, first_t, 49 + c_NCR);
    end
    tests++;
    if (oe_cnt != 48) begin
      fails++;
      $display("FAIL rsp_oe_cycles frame=%h got=%0d exp=48", frame, oe_cnt);
    end
    tests++;
    if (got !== e.rsp_bits) begin
      fails++;
      $display("FAIL rsp_bits frame=%h got=%h exp=%h", frame, got, e.rsp_bits);
    end
    tests++;
    if (bus.busy !== 1'b0 || bus.cmd_pin_oe !== 1'b0) begin
      fails++;
      $display("FAIL rsp_return_idle busy=%b oe=%b exp busy=0 oe=0", bus.busy, bus.cmd_pin_oe);
    end
  endtask

  task automatic idle(input int n);
    bus.cmd_pin_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_pin_in = 1'b1;
    bus.rsp_none   = 1'b0;
    bus.rsp_status = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.cmd_pin_oe !== 1'b0 || bus.cmd_pin_out !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_pins oe=%b out=%b busy=%b exp oe=0 out=1 busy=0",
               bus.cmd_pin_oe, bus.cmd_pin_out, bus.busy);
    end
    tests++;
    if (bus.cmd_valid !== 1'b0 || bus.cmd_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses valid=%b error=%b exp 0/0", bus.cmd_valid, bus.cmd_error);
    end
    tests++;
    if (bus.cmd_index !== 6'd0 || bus.cmd_argument !== 32'd0) begin
      fails++;
      $display("FAIL reset_fields idx=%0d arg=%h exp 0/0", bus.cmd_index, bus.cmd_argument);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cmd0_no_response();
    run_frame(48'h40_0000_0000_95, 32'hDEAD_BEEF, 1'b1, 1'b0, -1);
    for (int i = 0; i < 60; i++) begin
      tests++;
      if (bus.cmd_pin_oe !== 1'b0) begin
        fails++;
        $display("FAIL cmd0_oe_quiet cycle=%0d got=%b exp=0", i, bus.cmd_pin_oe);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cmd17_response();
    run_frame(48'h51_0000_0000_55, 32'h0000_0900, 1'b0, 1'b0, -1);
    idle(3);
  endtask

  task automatic test_crc_error();
    run_frame(48'h48_0000_01AA_87 ^ 48'h2, 32'h0000_01AA, 1'b0, 1'b0, -1);
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [39:0] body;
    body = {8'h58, 32'hFF99_FF88};
    run_frame({body, crc7(body), 1'b0}, 32'h0000_0900, 1'b0, 1'b0, -1);
    run_frame(48'h48_0000_01AA_87, 32'h0000_01AA, 1'b0, 1'b0, -1);
    idle(2);
  endtask

  task automatic test_toggle_during_send();
    logic [39:0] body;
    body = {8'h4D, 32'h1234_0000};
    run_frame({body, crc7(body), 1'b1}, 32'h8000_0900, 1'b0, 1'b1, -1);
    idle(2);
  endtask

  task automatic test_reset_mid_frame();
    logic [47:0] f;
    logic [39:0] body;
    f = 48'h51_0000_0000_55;
    for (int i = 47; i >= 20; i--) begin
      bus.cmd_pin_in = f[i];
      @(posedge clk); #1;
    end
    bus.cmd_pin_in = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (bus.cmd_pin_oe !== 1'b0 || bus.cmd_pin_out !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_recv oe=%b out=%b busy=%b exp oe=0 out=1 busy=0",
               bus.cmd_pin_oe, bus.cmd_pin_out, bus.busy);
    end
    rst     = 1'b0;
    exp_idx = '0;
    exp_arg = '0;
    idle(1);
    body = {8'h77, 32'h0000_0000};
    run_frame({body, crc7(body), 1'b1}, 32'h0000_0120, 1'b0, 1'b0, -1);
    idle(2);
    run_frame(48'h48_0000_01AA_87, 32'h0000_01AA, 1'b0, 1'b0, 10);
    idle(1);
    body = {8'h43, 32'hABCD_0000};
    run_frame({body, crc7(body), 1'b1}, 32'h5A5A_A5A5, 1'b0, 1'b0, -1);
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cmd0_no_response();
    test_cmd17_response();
    test_crc_error();
    test_back_to_back();
    test_toggle_during_send();
    test_reset_mid_frame();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_card_cmd_responder.md
# sd_card_cmd_responder

Card-side endpoint of the SD CMD line: deserializes 48-bit host command frames, checks framing and CRC7, hands index/argument to card logic, and drives back a 48-bit short response (R1/R3/R6/R7 format) after a programmable NCR gap. It is the counterpart of the host CMD engine. It serves as the behavioural card for host-side benches and as the front end of the card model.

## Interface
- NCR, default 2, response gap in clocks from the end of `cmd_valid` to the response start bit; legal range 2..64.
- clock  in  1  SD clock; CMD line sampled and driven on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_pin_in  in  1  CMD line as seen by the card (host drives).
- cmd_pin_out  out  1  response bit; reset 1.
- cmd_pin_oe  out  1  card drives CMD when 1; reset 0.
- cmd_valid  out  1  one-cycle pulse, good command received; reset 0.
- cmd_error  out  1  one-cycle pulse, bad CRC, transmission bit or end bit; reset 0.
- cmd_index  out  6  received index, held until next frame; reset 0.
- cmd_argument  out  32  received argument, held; reset 0.
- rsp_status  in  32  response payload; sampled in the `cmd_valid` cycle.
- rsp_none  in  1  suppress response (e.g. CMD0); sampled in the `cmd_valid` cycle.
- busy  out  1  high from start-bit detect until return to IDLE; reset 0.

## Operation
- States: IDLE, RECV, EVAL, GAP, SEND.
- **IDLE**
  - `cmd_pin_oe` = 0 and `cmd_pin_out` = 1.
  - Sampling `cmd_pin_in` = 0 counts as start bit 0 and moves to RECV.
- **RECV**
  - Shifts 47 further bits MSB-first into a 48-bit register.
  - CRC7 (x^7+x^3+1, init 0) runs over bits 47..8.
  - After bit 0, the end bit, move to EVAL.
- **EVAL** (one cycle)
  - Good frame: transmission bit (46) = 1, received CRC [7:1] equals computed CRC, end bit = 1.
  - Good frame: pulse `cmd_valid` and update `cmd_index`/`cmd_argument`.
    - If `rsp_none` = 0: latch `rsp_status`, go to GAP.
    - If `rsp_none` = 1: go to IDLE.
  - Bad frame: pulse `cmd_error`, leave `cmd_index`/`cmd_argument` unchanged, go to IDLE.
- **GAP**
  - Counts NCR clocks with `cmd_pin_oe` = 0, then moves to SEND.
- **SEND**
  - Drives 48 bits, MSB first: 0, 0, echoed index[5:0], status[31:0], CRC7 of the preceding 40 bits, 1.
  - `cmd_pin_oe` = 1 for exactly these 48 cycles.
  - After the end bit, go to IDLE.
- `cmd_pin_in` is ignored outside IDLE/RECV, so the card never re-receives its own response.
- `reset` in any state: next cycle all outputs take reset values, state is IDLE, counters and CRC are cleared, and any partial frame is discarded.

## Timing
- Cycle S samples the start bit. Cycle S+47 samples the end bit. `cmd_valid`/`cmd_error` are high in cycle S+48.
- The first response bit is driven in cycle S+49+NCR. The end bit is driven in S+96+NCR. `cmd_pin_oe` falls in S+97+NCR.
- Back-to-back frames: the cycle after EVAL returns to IDLE (bad frame or `rsp_none`), a start bit is accepted there.
- A 6-bit bit counter covers 0..47. A 6-bit gap counter loads NCR-1 and counts down to 0.
- CRC7 register is 7 bits, updated only on enabled shifts.

## Structure
- Package `sd_pkg` holds:
  - state enum
  - `SD_FRAME_BITS`=48, `SD_CRC_BITS`=7
  - `SD_CRC7_POLY`=7'h09
- Sub-module `sd_crc7` with ports `clock`, `reset`, `clear`, `enable`, `bit_in`, `crc[6:0]`.
  - One instance is time-shared: cleared at start-bit detect and again at SEND entry.
  - Reused later by the host CMD engine.

## Test plan
- CMD0 frame 0x40_0000_0000_95 with `rsp_none`=1 -> `cmd_valid` at S+48, index 0, arg 0, `cmd_pin_oe` never rises.
- CMD17 frame 0x51_0000_0000_55 with `rsp_status`=0x0000_0900, NCR=2 -> `cmd_valid`, index 17; response 0x11_0000_0900 plus the sd_crc7 value, end bit 1, start bit driven in S+51, `cmd_pin_oe` high for 48 cycles.
- CMD8 frame 0x48_0000_01AA_87 with one CRC bit flipped -> `cmd_error` at S+48, no response, `cmd_index`/`cmd_argument` retain previous values.
- CMD24 with arg 0xFF99_FF88 and end bit forced 0 -> `cmd_error`. The next valid frame starting at S+49 is accepted.
- Toggling `cmd_pin_in` every clock during SEND -> no start detect, response intact.
- Reset mid-RECV (bit 20) and mid-SEND (bit 10) -> next cycle `cmd_pin_oe`=0, `cmd_pin_out`=1, `busy`=0; the following clean frame is decoded correctly.
